cascade_counter: RTL and testbench
==================================

// Module: cascade_counter
// PURPOSE
//  Parametrised N-level cascaded time counter (sec/min/hr style) with an integrated tick prescaler.
//  Entirely single-clock: the prescaler drives a one-cycle tick enable; no derived clocks.
//  Levels ripple correctly; a new value is loaded through a valid/ready handshake.
//  Sits between the board clock and the display/alarm logic of the clock design.
// PARAMETERS
//  CLK_FREQ  1000000           input clock frequency, Hz
//  TICK_HZ   1                 level-0 count rate, Hz; DIV = CLK_FREQ/TICK_HZ (must be >= 2)
//  LEVELS    3                 number of cascaded levels (1..8)
//  DIGIT_W   6                 bits per level value
//  MAX_VALS  {6'd59,6'd59,6'd59}  packed LEVELS*DIGIT_W; field i = max value of level i (level 0 in LSBs)
// PORTS
//  clock       in   1                 system clock, all logic on posedge
//  reset       in   1                 synchronous, active-high
//  enabled     in   1                 1 = prescaler and counting run; 0 = hold
//  load_valid  in   1                 load request
//  load_ready  out  1                 load can be accepted this cycle
//  load_data   in   LEVELS*DIGIT_W    packed load values, level 0 in LSBs
//  count_out   out  LEVELS*DIGIT_W    packed current level values, level 0 in LSBs
//  tick        out  1                 one-cycle pulse, aligned with each count_out step
//  carry_out   out  1                 one-cycle pulse when the top level wraps
// BEHAVIOUR
//  Reset: prescaler=0, count_out=0, tick=0, carry_out=0, load_ready=0. Reset overrides everything.
//  load_ready: registered; 0 in the reset cycle and the cycle after, then 1.
//  Prescaler: counts 0..DIV-1 while enabled. At DIV-1 it returns to 0 and the step fires (internal).
//   enabled=0 holds the prescaler value; it does not clear it.
//  Step: level 0 advances; level i advances only if levels 0..i-1 are all at max.
//   Wrap: a level at max goes to 0. count_out, tick and carry_out update on the same clock edge,
//   i.e. the edge after the prescaler reads DIV-1.
//  carry_out=1 only for a step where every level is at max (count_out becomes all zeros).
//  Load: accepted on load_valid && load_ready. The next edge sets count_out to load_data,
//   with each field > its MAX_VALS field replaced by 0. The prescaler clears to 0.
//   The step is suppressed that cycle (tick=0, carry_out=0). Load wins over a coincident step.
//   Load is accepted even when enabled=0.
//  Arithmetic: unsigned, DIGIT_W bits; compares use >= max so out-of-range values wrap safely.
//  Reset mid-count: the next cycle shows all zeros; any pending load is dropped.
// CONFIGURATION
//  CASCADE_COUNTER_DOWN_EN defined:
//   Adds input port direction (1 bit): 0 = up, 1 = down.
//   Down: level 0 decrements. Level i decrements only if levels 0..i-1 are all 0. 0 wraps to max.
//   carry_out pulses on the all-zero -> all-max borrow.
//  Undefined: no direction port; the block is up-count only.
// STRUCTURE
//  Shared include clock_defs.vh:
//   clog2 function.
//   Default max constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23.
//   Packed-field extract macro FIELD(v,i,w).
//  Sub-module tick_prescaler:
//   Parameter DIV; ports clock, reset, enabled, clear, tick.
//   Counter width clog2(DIV).
//  Top level: generate loop over LEVELS computing the per-level "all lower at max" chain.
// TESTING (sim params CLK_FREQ=10, TICK_HZ=1 -> DIV=10; default LEVELS/MAX_VALS)
//  Reset, then enabled=1 for 30 cycles:
//   tick pulses every 10 cycles; count_out level0 = 1, 2, 3; carry_out never asserts.
//  Load {2'h.., 59,59,58} (l2=59,l1=59,l0=58), then 2 steps:
//   after 1st step 59/59/59; after 2nd step 0/0/0 with carry_out=1 for exactly one cycle.
//  Load l0=59,l1=5 then 1 step -> l0=0, l1=6, l2 unchanged. Load l1=59 alone, step -> l1 stays 59.
//  Load with l0=63, l1=60 -> count_out l0=0, l1=0. Load coincident with prescaler=DIV-1 ->
//   load value shown, tick=0, next tick 10 cycles later.
//  enabled=0 at prescaler=4 for 7 cycles -> count_out frozen; tick resumes 6 cycles after re-enable.
//   reset mid-run -> zeros, load_ready=0 for 2 cycles.
//  CASCADE_COUNTER_DOWN_EN, direction=1, load 0/0/0, 1 step -> 59/59/59 with carry_out=1.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared definitions for the cascaded time counter: default per-level maxima,
// count direction encoding and a constant-foldable ceil(log2) helper.
package cascade_counter_pkg;

  localparam int unsigned MAX_SEC = 59;
  localparam int unsigned MAX_MIN = 59;
  localparam int unsigned MAX_HR  = 23;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Smallest r with 2**r >= v; used to size the prescaler counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < v; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cascade_counter_tick_prescaler.sv
// Single-clock prescaler: counts 0..DIV-1 while enabled and raises a one-cycle
// tick (combinational) while it sits at DIV-1, i.e. in the cycle whose closing
// edge wraps it back to 0. Holding enabled low freezes the count; clear forces
// it back to 0 on the next edge.
module tick_prescaler
  import cascade_counter_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic enabled,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enabled && (cnt_q == LAST);

  // Next prescaler value: clear beats wrap beats increment; disabled holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enabled) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// Cascaded N-level time counter (sec/min/hr style) with built-in prescaler.
// Level 0 steps once per DIV = CLK_FREQ/TICK_HZ clocks (DIV must be >= 2);
// level i steps only when every lower level wraps on the same step. A new
// value is loaded through load_valid/load_ready; out-of-range fields load as 0.
// Optional macro CASCADE_COUNTER_DOWN_EN adds a 'direction' input (1 = down).
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 1000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned LEVELS   = 3,
  parameter int unsigned DIGIT_W  = 6,
  parameter logic [LEVELS*DIGIT_W-1:0] MAX_VALS = {6'd59, 6'd59, 6'd59}
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enabled,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [LEVELS*DIGIT_W-1:0]   load_data,
  output logic [LEVELS*DIGIT_W-1:0]   count_out,
  output logic                        tick,
  output logic                        carry_out
`ifdef CASCADE_COUNTER_DOWN_EN
  ,
  input  logic                        direction
`endif
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned VW  = LEVELS * DIGIT_W;

  // Replace every field above its level maximum by zero.
  function automatic logic [VW-1:0] clamp_load(input logic [VW-1:0] v);
    logic [DIGIT_W-1:0] f;
    clamp_load = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      f = v[k*DIGIT_W +: DIGIT_W];
      clamp_load[k*DIGIT_W +: DIGIT_W] =
        (f > MAX_VALS[k*DIGIT_W +: DIGIT_W]) ? '0 : f;
    end
  endfunction

  dir_e dir;
`ifdef CASCADE_COUNTER_DOWN_EN
  assign dir = dir_e'(direction);
`else
  assign dir = DIR_UP;
`endif

  logic [VW-1:0] count_q;
  logic [VW-1:0] count_d;
  logic          tick_q;
  logic          carry_q;
  logic          rdy_arm_q;
  logic          load_ready_q;
  logic          step;
  logic          load_acc;
  logic          all_lim;

  assign load_acc = load_valid && load_ready_q;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enabled(enabled),
    .clear  (load_acc),
    .tick   (step)
  );

  // Per-level next value and the "all lower levels at their limit" chain.
  // The limit is max for up-counting (>= so stray values still wrap) and
  // zero for down-counting.
  for (genvar i = 0; i < int'(LEVELS); i++) begin : g_lvl
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] lim;
    logic               at_lim;
    logic               lower_lim;

    assign cur    = count_q[i*DIGIT_W +: DIGIT_W];
    assign lim    = MAX_VALS[i*DIGIT_W +: DIGIT_W];
    assign at_lim = (dir == DIR_DOWN) ? (cur == '0) : (cur >= lim);

    if (i == 0) begin : g_first
      assign lower_lim = 1'b1;
    end else begin : g_rest
      assign lower_lim = g_lvl[i-1].lower_lim & g_lvl[i-1].at_lim;
    end

    assign count_d[i*DIGIT_W +: DIGIT_W] =
      !lower_lim         ? cur :
      (dir == DIR_DOWN)  ? (at_lim ? lim : cur - 1'b1) :
                           (at_lim ? '0  : cur + 1'b1);
  end

  assign all_lim = g_lvl[LEVELS-1].lower_lim & g_lvl[LEVELS-1].at_lim;

  // load_ready comes up two edges after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_arm_q    <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      rdy_arm_q    <= 1'b1;
      load_ready_q <= rdy_arm_q;
    end
  end

  // Count register with aligned tick/carry pulses; a load suppresses the step.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (load_acc) begin
      count_q <= clamp_load(load_data);
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      tick_q  <= step;
      carry_q <= step && all_lim;
      if (step) begin
        count_q <= count_d;
      end
    end
  end

  assign load_ready = load_ready_q;
  assign count_out  = count_q;
  assign tick       = tick_q;
  assign carry_out  = carry_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter (DIV = 10, three levels of 0..59).
// Stimulus pushes the expected edge number, count, tick and carry for every
// tick and every accepted load; a negedge monitor pops and compares whenever
// the DUT shows tick, carry or a just-accepted load.
// Build with CASCADE_COUNTER_DOWN_EN to add the down-count case.
`timescale 1ns/1ps
module tb_cascade_counter;

  localparam int VW = 18;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          enabled    = 1'b0;
  logic          load_valid = 1'b0;
  logic [VW-1:0] load_data  = '0;
  logic          load_ready;
  logic [VW-1:0] count_out;
  logic          tick;
  logic          carry_out;
`ifdef CASCADE_COUNTER_DOWN_EN
  logic          direction  = 1'b0;
`endif

  always #5 clock = ~clock;

  cascade_counter #(
    .CLK_FREQ(10),
    .TICK_HZ (1),
    .LEVELS  (3),
    .DIGIT_W (6),
    .MAX_VALS({6'd59, 6'd59, 6'd59})
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enabled   (enabled),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .count_out (count_out),
    .tick      (tick),
    .carry_out (carry_out)
`ifdef CASCADE_COUNTER_DOWN_EN
    ,
    .direction (direction)
`endif
  );

  typedef struct {
    int          edge_n;
    logic [VW-1:0] cnt;
    logic        tk;
    logic        cy;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic acc_q = 1'b0;
  logic rst_q = 1'b1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [VW-1:0] pk(int l2, int l1, int l0);
    return {6'(l2), 6'(l1), 6'(l0)};
  endfunction

  task automatic push(int e, logic [VW-1:0] c, logic t, logic y);
    exp_t x;
    x.edge_n = e;
    x.cnt    = c;
    x.tk     = t;
    x.cy     = y;
    sb_q.push_back(x);
  endtask

  task automatic wait_to(int e);
    while (cyc < e) @(negedge clock);
  endtask

  // Load presented now is taken on the next edge; its result is expected there.
  task automatic do_load(logic [VW-1:0] d, logic [VW-1:0] expv);
    push(cyc + 1, expv, 1'b0, 1'b0);
    load_data  = d;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  // Edge counter and handshake/reset observation at the active edge.
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    acc_q <= load_valid && load_ready && !reset;
    rst_q <= reset;
  end

  // Monitor: compare each visible output event against the scoreboard head.
  always @(negedge clock) begin
    if (!rst_q && (tick || carry_out || acc_q)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: edge %0d count %0h tick %0b carry %0b, none required",
                 cyc, count_out, tick, carry_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("event_edge",  cyc,       e.edge_n);
        chk("event_count", count_out, e.cnt);
        chk("event_tick",  tick,      e.tk);
        chk("event_carry", carry_out, e.cy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_to(2);
    chk("reset_count", count_out, '0);
    chk("reset_tick",  tick,      1'b0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_ready", load_ready, 1'b0);
    reset   = 1'b0;
    enabled = 1'b1;
    push(12, pk(0, 0, 1), 1'b1, 1'b0);
    push(22, pk(0, 0, 2), 1'b1, 1'b0);
    push(32, pk(0, 0, 3), 1'b1, 1'b0);
    wait_to(3);
    chk("ready_cycle_after_reset", load_ready, 1'b0);
    wait_to(4);
    chk("ready_up", load_ready, 1'b1);
    wait_to(32);

    // Full ripple into carry
    do_load(pk(59, 59, 58), pk(59, 59, 58));
    push(43, pk(59, 59, 59), 1'b1, 1'b0);
    push(53, pk(0, 0, 0),    1'b1, 1'b1);
    wait_to(53);

    // Level 0 wrap advances level 1 only
    do_load(pk(7, 5, 59), pk(7, 5, 59));
    push(64, pk(7, 6, 0), 1'b1, 1'b0);
    wait_to(64);

    // Level 1 at max alone does not move
    do_load(pk(3, 59, 10), pk(3, 59, 10));
    push(75, pk(3, 59, 11), 1'b1, 1'b0);
    wait_to(75);

    // Out-of-range fields load as zero
    do_load(pk(23, 60, 63), pk(23, 0, 0));
    wait_to(85);

    // Load coincident with prescaler = DIV-1 wins over the step
    do_load(pk(1, 2, 3), pk(1, 2, 3));
    push(96, pk(1, 2, 4), 1'b1, 1'b0);
    wait_to(100);

    // Hold at prescaler = 4 for 7 cycles
    enabled = 1'b0;
    push(113, pk(1, 2, 5), 1'b1, 1'b0);
    wait_to(107);
    chk("hold_count", count_out, pk(1, 2, 4));
    enabled = 1'b1;
    wait_to(113);

    // Reset mid-run with a pending load
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = pk(5, 5, 5);
    wait_to(114);
    chk("midreset_count", count_out, '0);
    chk("midreset_tick",  tick,      1'b0);
    chk("midreset_ready", load_ready, 1'b0);
    reset = 1'b0;
    wait_to(115);
    chk("midreset_ready_2", load_ready, 1'b0);
    chk("midreset_load_dropped", count_out, '0);
    load_valid = 1'b0;
    wait_to(116);
    chk("midreset_ready_up", load_ready, 1'b1);
    do_load(pk(5, 5, 5), pk(5, 5, 5));
    push(127, pk(5, 5, 6), 1'b1, 1'b0);
    wait_to(127);

`ifdef CASCADE_COUNTER_DOWN_EN
    // Down-count borrow from all zeros
    direction = 1'b1;
    do_load(pk(0, 0, 0), pk(0, 0, 0));
    push(138, pk(59, 59, 59), 1'b1, 1'b1);
    wait_to(138);
    direction = 1'b0;
`endif

    wait_to(cyc + 3);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
